// File: rtl/inst_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// The optional address guard is controlled by INST_RESP_ADDR_GUARD_EN (see inst_mem_responder.sv).
package inst_mem_responder_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 32;
    localparam int MEM_W_DEF  = 8;

    typedef logic [ADDR_W_DEF-1:0] ADDR_TYPE;
    typedef logic [INST_W_DEF-1:0] INST_TYPE;
    typedef logic [MEM_W_DEF-1:0]  MEM_BYTE_TYPE;

    localparam INST_TYPE ZERO_WORD    = 32'h0000_0000;
    localparam INST_TYPE NOP_INST     = 32'h0000_0013;
    localparam ADDR_TYPE IO_BASE_ADDR = 32'h0003_0000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // byte counter: 0..4 within a read sequence
    localparam int CNT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: serves one 32-bit instruction as four
// little-endian byte reads from the byte-wide unified RAM.
// Optional feature macro: INST_RESP_ADDR_GUARD_EN -- when defined, unaligned
// or IO-region query addresses return a NOP without touching the RAM.
//
// state | meaning
// IDLE  | waiting for start_query_signal; finish pulse lives here for one cycle
// READ  | issuing byte addresses base..base+3 and assembling returned bytes
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                INST_W  = INST_W_DEF,
    parameter int                MEM_W   = MEM_W_DEF,
    parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              start_query_signal,
    input  logic [ADDR_W-1:0] query_pc,
    input  logic              stop_signal,
    output logic              finish_query_signal,
    output logic [INST_W-1:0] queried_inst,
    output logic              busy,
    input  logic [MEM_W-1:0]  mem_din,
    output logic [MEM_W-1:0]  mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

`ifdef INST_RESP_ADDR_GUARD_EN
    localparam logic GUARD_EN = TRUE;
`else
    localparam logic GUARD_EN = FALSE;
`endif

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [ADDR_W-1:0]  base, base_next;
    logic [ADDR_W-1:0]  mem_a_next;
    logic [INST_W-1:0]  asm_word, asm_next;
    logic [INST_W-1:0]  inst_next;
    logic               busy_next, finish_next;
    logic               addr_bad;

    // Place one RAM byte into its little-endian lane of the assembly word.
    function automatic logic [INST_W-1:0] put_lane(input logic [INST_W-1:0] word,
                                                   input logic [1:0]        lane,
                                                   input logic [MEM_W-1:0]  data);
        logic [INST_W-1:0] w;
        w = word;
        w[lane*MEM_W +: MEM_W] = data;
        return w;
    endfunction

    // Read-only port toward the RAM.
    assign mem_dout = '0;
    assign mem_wr   = FALSE;

    assign addr_bad = GUARD_EN && ((query_pc[1:0] != 2'b00) || (query_pc >= IO_BASE));

    // Next-state, address sequencing and byte assembly.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        base_next   = base;
        mem_a_next  = mem_a;
        asm_next    = asm_word;
        inst_next   = queried_inst;
        busy_next   = busy;
        finish_next = FALSE;

        if (stop_signal) begin
            state_next = IDLE;
            cnt_next   = '0;
            mem_a_next = '0;
            busy_next  = FALSE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_query_signal) begin
                        if (addr_bad) begin
                            inst_next   = NOP_INST;
                            finish_next = TRUE;
                        end else begin
                            base_next  = query_pc;
                            mem_a_next = query_pc;
                            cnt_next   = '0;
                            busy_next  = TRUE;
                            state_next = READ;
                        end
                    end
                end
                READ: begin
                    // data for the address issued two edges ago is on mem_din
                    if (cnt >= CNT_W'(1)) begin
                        asm_next = put_lane(asm_word, 2'(cnt - CNT_W'(1)), mem_din);
                    end
                    if (cnt == CNT_W'(4)) begin
                        inst_next   = asm_next;
                        finish_next = TRUE;
                        busy_next   = FALSE;
                        state_next  = IDLE;
                        cnt_next    = '0;
                        mem_a_next  = '0;
                    end else begin
                        mem_a_next = (cnt < CNT_W'(3)) ? base + ADDR_W'(cnt) + ADDR_W'(1) : '0;
                        cnt_next   = cnt + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and output registers; everything freezes while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            base                <= '0;
            mem_a               <= '0;
            asm_word            <= '0;
            queried_inst        <= '0;
            busy                <= FALSE;
            finish_query_signal <= FALSE;
        end else if (rdy) begin
            state               <= state_next;
            cnt                 <= cnt_next;
            base                <= base_next;
            mem_a               <= mem_a_next;
            asm_word            <= asm_next;
            queried_inst        <= inst_next;
            busy                <= busy_next;
            finish_query_signal <= finish_next;
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench for inst_mem_responder with a registered byte-RAM model.
module tb_inst_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        start_query_signal = 1'b0;
    logic [31:0] query_pc = '0;
    logic        stop_signal = 1'b0;
    logic        finish_query_signal;
    logic [31:0] queried_inst;
    logic        busy;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] sb[$];

    inst_mem_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .start_query_signal  (start_query_signal),
        .query_pc            (query_pc),
        .stop_signal         (stop_signal),
        .finish_query_signal (finish_query_signal),
        .queried_inst        (queried_inst),
        .busy                (busy),
        .mem_din             (mem_din),
        .mem_dout            (mem_dout),
        .mem_a               (mem_a),
        .mem_wr              (mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h1002: return 8'h00;
            32'h1003: return 8'h00;
            default:  return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
`ifdef INST_RESP_ADDR_GUARD_EN
        if (pc[1:0] != 2'b00 || pc >= 32'h0003_0000) return 32'h0000_0013;
`endif
        return {ram_byte(pc + 32'd3), ram_byte(pc + 32'd2), ram_byte(pc + 32'd1), ram_byte(pc)};
    endfunction

    // RAM: read data valid the cycle after the address; frozen with rdy
    always @(posedge clk) if (rdy) mem_din <= ram_byte(mem_a);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // scoreboard pop on every completion pulse
    always @(negedge clk) begin
        if (rst && rdy && finish_query_signal) begin
            if (sb.size() == 0) check_eq("finish_unexpected", 64'd1, 64'd0);
            else check_eq("inst", queried_inst, sb.pop_front());
        end
    end

    task automatic issue(input logic [31:0] pc, input bit expect_done);
        query_pc = pc;
        start_query_signal = 1'b1;
        if (expect_done) sb.push_back(exp_word(pc));
        @(negedge clk);
        start_query_signal = 1'b0;
    endtask

    task automatic wait_finish(output int at);
        at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (finish_query_signal) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_eq("finish_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, a1, a2;

        // reset state
        repeat (2) @(negedge clk);
        check_eq("rst_finish", finish_query_signal, 0);
        check_eq("rst_inst",   queried_inst, 0);
        check_eq("rst_mem_a",  mem_a, 0);
        check_eq("rst_busy",   busy, 0);
        check_eq("rst_mem_wr", mem_wr, 0);
        check_eq("rst_mem_dout", mem_dout, 0);
        rst = 1'b1;
        @(negedge clk);

        // basic fetch of 0x1000
        issue(32'h1000, 1'b1);
        c0 = cyc;
        check_eq("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_mem_a", mem_a, 32'h1000 + i);
            check_eq("t1_no_finish", finish_query_signal, 0);
            @(negedge clk);
        end
        check_eq("t1_mem_a_idle", mem_a, 0);
        wait_finish(a1);
        check_eq("t1_latency", a1 - c0, 5);
        check_eq("t1_word", queried_inst, 32'h0000_0513);
        check_eq("t1_busy_done", busy, 0);
        @(negedge clk);
        check_eq("t1_pulse_len", finish_query_signal, 0);
        check_eq("t1_inst_hold", queried_inst, 32'h0000_0513);

        // back-to-back with re-request in the finish cycle
        issue(32'h0, 1'b1);
        wait_finish(a1);
        check_eq("t2_busy_gap", busy, 0);
        issue(32'h4, 1'b1);
        check_eq("t2_busy_again", busy, 1);
        wait_finish(a2);
        check_eq("t2_spacing", a2 - a1, 6);

        // stop two cycles into a read
        issue(32'h2000, 1'b0);
        @(negedge clk);
        stop_signal = 1'b1;
        @(negedge clk);
        stop_signal = 1'b0;
        check_eq("t3_busy", busy, 0);
        check_eq("t3_mem_a", mem_a, 0);
        repeat (6) @(negedge clk);
        check_eq("t3_inst_kept", queried_inst, exp_word(32'h4));
        issue(32'h2004, 1'b1);
        wait_finish(a1);

        // start and stop together
        query_pc = 32'h3000;
        start_query_signal = 1'b1;
        stop_signal = 1'b1;
        @(negedge clk);
        start_query_signal = 1'b0;
        stop_signal = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq("t4_mem_a", mem_a, 0);
            check_eq("t4_busy", busy, 0);
            @(negedge clk);
        end

        // rdy low three cycles mid-read
        issue(32'h1000, 1'b1);
        c0 = cyc;
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t5_mem_a_hold", mem_a, 32'h1001);
        check_eq("t5_busy_hold", busy, 1);
        rdy = 1'b1;
        wait_finish(a1);
        check_eq("t5_latency", a1 - c0, 8);
        check_eq("t5_word", queried_inst, 32'h0000_0513);

`ifdef INST_RESP_ADDR_GUARD_EN
        // guarded IO address returns NOP next cycle
        issue(32'h0003_0000, 1'b1);
        check_eq("t7_finish", finish_query_signal, 1);
        check_eq("t7_mem_a", mem_a, 0);
        check_eq("t7_nop", queried_inst, 32'h0000_0013);
        @(negedge clk);
`else
        // address wrap
        issue(32'hFFFF_FFFE, 1'b1);
        check_eq("t6_mem_a0", mem_a, 32'hFFFF_FFFE);
        @(negedge clk);
        check_eq("t6_mem_a1", mem_a, 32'hFFFF_FFFF);
        @(negedge clk);
        check_eq("t6_mem_a2", mem_a, 32'h0000_0000);
        @(negedge clk);
        check_eq("t6_mem_a3", mem_a, 32'h0000_0001);
        wait_finish(a1);

        // IO address read normally
        issue(32'h0003_0000, 1'b1);
        check_eq("t7_mem_a", mem_a, 32'h0003_0000);
        wait_finish(a1);
`endif

        // async reset mid-read
        issue(32'h1000, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("t8_busy", busy, 0);
        check_eq("t8_mem_a", mem_a, 0);
        check_eq("t8_inst", queried_inst, 0);
        check_eq("t8_finish", finish_query_signal, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(32'h0000_0010, 1'b1);
        wait_finish(a1);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Memory-side responder for the instruction-fetch query protocol. Serves the fetcher's start-query pulse, query PC and stop signal.
- Reads one 32-bit instruction from the byte-wide unified RAM as four little-endian byte reads. Returns it with a one-cycle finish pulse.
- Sits between the fetcher and the RAM port, inside the memory-controller region of the design.

Parameters:
- ADDR_W, 32, address width of query PC and RAM address.
- INST_W, 32, instruction width; must equal 4*MEM_W.
- MEM_W, 8, RAM data-bus width.
- IO_BASE, 32'h0003_0000, first address of the IO region; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- rdy  in  1  global ready; when 0, every register holds.
- start_query_signal  in  1  one-cycle request pulse from the fetcher.
- query_pc  in  ADDR_W  instruction address, valid with start_query_signal.
- stop_signal  in  1  abort: discard any request in progress.
- finish_query_signal  out  1  one-cycle completion pulse.
- queried_inst  out  INST_W  assembled instruction, valid with the finish pulse.
- busy  out  1  high while a request is in progress.
- mem_din  in  MEM_W  RAM read data; valid in the cycle after its address is driven.
- mem_dout  out  MEM_W  RAM write data; constant 0.
- mem_a  out  ADDR_W  RAM address.
- mem_wr  out  1  RAM write enable; constant 0 (read-only responder).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, base=0.
  - finish_query_signal=0, queried_inst=0, mem_a=0, busy=0.
  - mem_wr=0 and mem_dout=0 at all times.
- rdy=0: all state and outputs hold, including a pending finish pulse. The RAM is frozen too, so the sequence stays consistent.
- IDLE state:
  - finish_query_signal defaults to 0 every rdy cycle.
  - On start_query_signal=1 and stop_signal=0: base<=query_pc, mem_a<=query_pc, cnt<=0, busy<=1, state<=READ.
- READ state, per rdy edge:
  - mem_a <= base+cnt+1 while cnt<3; otherwise mem_a<=0.
  - Once cnt>=1, capture mem_din into byte lane cnt-1 of the assembly register.
  - cnt increments each edge.
- Completion: on the edge where cnt=4, capture lane 3 and load queried_inst with all four lanes. Byte 0 goes to bits 7:0 (little-endian). Set finish_query_signal<=1, busy<=0, state<=IDLE.
- Timing: request sampled at edge E0 → mem_a = pc, pc+1, pc+2, pc+3 in the following four cycles → finish high in the cycle after E5 (5 cycles after request).
- Throughput: one instruction per 6 cycles, including the fetcher's re-request turnaround.
- queried_inst holds its value until the next completion.
- stop_signal=1 (any state, rdy=1): state<=IDLE, cnt<=0, mem_a<=0, busy<=0, finish<=0. The partial word is discarded and queried_inst is unchanged.
- Simultaneous stop and start: stop wins; the request is dropped.
- Start while in READ: ignored; the protocol forbids it.
- Address arithmetic is modulo 2^ADDR_W; base+3 wraps without error.
- A finish pulse already registered is not retracted by a stop arriving in the same cycle as the pulse. The fetcher ignores it because it has left BUSY.

Optional Feature:
- Macro: INST_RESP_ADDR_GUARD_EN.
- Enabled: a request whose query_pc has a nonzero [1:0], or whose query_pc >= IO_BASE, skips RAM. The next edge sets queried_inst=32'h0000_0013 (NOP) and finish_query_signal=1; mem_a stays 0. This prevents speculative fetches from consuming IO reads.
- Disabled: all addresses are read from RAM as normal.

Decomposition:
- Shared constants header: ADDR_TYPE, INST_TYPE, MEM_BYTE_TYPE, ZERO_WORD, NOP_INST, IO_BASE_ADDR, TRUE/FALSE.
- No sub-module. The FSM, counter and assembly register form one block. Byte-lane assembly is a small inline function.

Test Plan:
- RAM[0x1000..0x1003]=13 05 00 00, start with pc=0x1000 → mem_a=0x1000,0x1001,0x1002,0x1003 in consecutive cycles; finish one cycle, 5 cycles after start; queried_inst=0x00000513.
- Back-to-back: pc=0x0, then re-request pc=0x4 the cycle after finish → two finishes 6 cycles apart, correct words, busy low only between them.
- stop_signal pulsed 2 cycles into a read of 0x2000 → no finish, busy=0 next cycle, queried_inst keeps its previous value; a new request for 0x2004 completes normally.
- start and stop in the same cycle → no read (mem_a stays 0), no finish.
- rdy held 0 for 3 cycles mid-read → completion delayed exactly 3 cycles, word correct. Async reset asserted mid-read → outputs zero immediately.
- With INST_RESP_ADDR_GUARD_EN: pc=0x30000 → finish next cycle, inst=0x00000013, mem_a=0. Without it: mem_a=0x30000 is issued.
